// File: rtl/class_pop_scheduler_pkg.sv
// Shared definitions for the class pop scheduler: FSM state encodings and class indices.
package class_pop_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } sched_state_t;

  localparam logic CLASS0 = 1'b0;
  localparam logic CLASS1 = 1'b1;

endpackage

// File: rtl/class_pop_scheduler_burst_counter.sv
// Burst counter for the weighted round-robin turn: counts pops in the current turn
// and flags the pop that brings the count up to the class weight.
module class_burst_counter #(
  parameter int WCNT_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [WCNT_SIZE-1:0] weight,
  output logic                 terminal
);

  logic [WCNT_SIZE-1:0] count_reg;
  logic [WCNT_SIZE-1:0] count_next;
  logic [WCNT_SIZE-1:0] count_inc;

  assign count_inc = count_reg + WCNT_SIZE'(1);
  // Terminal is judged on the post-increment value so the turn ends on the weight-th pop.
  assign terminal  = inc && (count_inc == weight);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/class_pop_scheduler.sv
// Weighted round-robin pop scheduler sharing one output link between two class FIFOs,
// with registered link outputs, upstream pause forwarding, pop counters and sticky error.
module class_pop_scheduler
  import class_pop_scheduler_pkg::*;
#(
  parameter int DATA_SIZE = 10,
  parameter int WEIGHT0   = 3,
  parameter int WEIGHT1   = 1,
  parameter int WCNT_SIZE = 3,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty0,
  input  logic                 fifo_empty1,
  input  logic                 almost_full0,
  input  logic                 almost_full1,
  input  logic                 fifo_error0,
  input  logic                 fifo_error1,
  input  logic [DATA_SIZE-1:0] data0,
  input  logic [DATA_SIZE-1:0] data1,
  input  logic                 af_down0,
  input  logic                 af_down1,
  output logic                 pop0,
  output logic                 pop1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 class_out,
  output logic                 pause_up0,
  output logic                 pause_up1,
  output logic [CNT_SIZE-1:0]  pop_cnt0,
  output logic [CNT_SIZE-1:0]  pop_cnt1,
  output logic                 Error
);

  localparam logic [WCNT_SIZE-1:0] W0 = WCNT_SIZE'(WEIGHT0);
  localparam logic [WCNT_SIZE-1:0] W1 = WCNT_SIZE'(WEIGHT1);

  sched_state_t state_reg, state_next;
  logic         last_reg, last_next;
  logic         cur_cls;
  logic [1:0]   elig;
  logic [1:0]   pop_vec;
  logic [1:0]   almost_full_vec;
  logic [1:0]   pause_vec;
  logic [1:0][CNT_SIZE-1:0] pop_cnt_vec;
  logic         cnt_clr, cnt_inc, cnt_terminal;
  logic [WCNT_SIZE-1:0] weight_sel;

  logic [DATA_SIZE-1:0] data_out_reg;
  logic                 valid_out_reg;
  logic                 class_out_reg;
  logic                 error_reg;

  assign elig            = {!fifo_empty1 && !af_down1, !fifo_empty0 && !af_down0};
  assign almost_full_vec = {almost_full1, almost_full0};
  assign cur_cls         = (state_reg == SERVE1) ? CLASS1 : CLASS0;
  assign weight_sel      = (state_reg == SERVE1) ? W1 : W0;

  class_burst_counter #(
    .WCNT_SIZE(WCNT_SIZE)
  ) u_burst (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .weight  (weight_sel),
    .terminal(cnt_terminal)
  );

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    pop_vec    = 2'b00;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_clr = 1'b1;
        if (elig[0] && elig[1]) begin
          state_next = (last_reg == CLASS0) ? SERVE1 : SERVE0;
        end else if (elig[0]) begin
          state_next = SERVE0;
        end else if (elig[1]) begin
          state_next = SERVE1;
        end
      end
      SERVE0, SERVE1: begin
        // Gating by eligibility here means af_down stops pops in the very cycle it rises.
        pop_vec[cur_cls] = elig[cur_cls];
        cnt_inc          = elig[cur_cls];
        if (cnt_terminal || !elig[cur_cls]) begin
          cnt_clr   = 1'b1;
          last_next = cur_cls;
          if (elig[~cur_cls]) begin
            state_next = (cur_cls == CLASS1) ? SERVE0 : SERVE1;
          end else if (elig[cur_cls]) begin
            state_next = state_reg;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      last_reg  <= CLASS1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      class_out_reg <= CLASS0;
      error_reg     <= 1'b0;
    end else begin
      valid_out_reg <= |pop_vec;
      if (|pop_vec) begin
        data_out_reg  <= pop_vec[1] ? data1 : data0;
        class_out_reg <= pop_vec[1];
      end
      error_reg <= error_reg | fifo_error0 | fifo_error1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      logic [CNT_SIZE-1:0] cnt_reg;
      logic                pause_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg   <= '0;
          pause_reg <= 1'b0;
        end else begin
          if (pop_vec[gi]) begin
            cnt_reg <= cnt_reg + CNT_SIZE'(1);
          end
          pause_reg <= almost_full_vec[gi];
        end
      end

      assign pop_cnt_vec[gi] = cnt_reg;
      assign pause_vec[gi]   = pause_reg;
    end
  endgenerate

  assign pop0      = pop_vec[0];
  assign pop1      = pop_vec[1];
  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign class_out = class_out_reg;
  assign pause_up0 = pause_vec[0];
  assign pause_up1 = pause_vec[1];
  assign pop_cnt0  = pop_cnt_vec[0];
  assign pop_cnt1  = pop_cnt_vec[1];
  assign Error     = error_reg;

endmodule

// File: tb/tb_class_pop_scheduler.sv
// Directed, table-driven bench for class_pop_scheduler with queue-based FIFO models.
module tb_class_pop_scheduler;

  localparam int DW = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty0, fifo_empty1;
  logic          almost_full0, almost_full1;
  logic          fifo_error0, fifo_error1;
  logic [DW-1:0] data0, data1;
  logic          af_down0, af_down1;
  logic          pop0, pop1;
  logic [DW-1:0] data_out;
  logic          valid_out, class_out;
  logic          pause_up0, pause_up1;
  logic [CW-1:0] pop_cnt0, pop_cnt1;
  logic          error_flag;

  always #5 clk = ~clk;

  class_pop_scheduler #(
    .DATA_SIZE(DW), .WEIGHT0(3), .WEIGHT1(1), .WCNT_SIZE(3), .CNT_SIZE(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
    .almost_full0(almost_full0), .almost_full1(almost_full1),
    .fifo_error0(fifo_error0), .fifo_error1(fifo_error1),
    .data0(data0), .data1(data1),
    .af_down0(af_down0), .af_down1(af_down1),
    .pop0(pop0), .pop1(pop1),
    .data_out(data_out), .valid_out(valid_out), .class_out(class_out),
    .pause_up0(pause_up0), .pause_up1(pause_up1),
    .pop_cnt0(pop_cnt0), .pop_cnt1(pop_cnt1),
    .Error(error_flag)
  );

  typedef struct {
    logic af0, af1;   // downstream almost-full inputs for this cycle
    logic p0, p1;     // expected pop strobes this cycle
    logic v, cls;     // expected valid_out / class_out this cycle
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] base0 = 10'h040;
  logic [DW-1:0] base1 = 10'h300;
  logic [DW-1:0] exp_word;
  int k0, k1;
  vec_t tbl2[9];
  vec_t tbl3[8];
  vec_t tbl4[19];

  function automatic vec_t mk(input logic a0, a1, p0, p1, v, c);
    vec_t r;
    r.af0 = a0; r.af1 = a1; r.p0 = p0; r.p1 = p1; r.v = v; r.cls = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic apply_fifo();
    fifo_empty0 = (q0.size() == 0);
    fifo_empty1 = (q1.size() == 0);
    data0 = (q0.size() != 0) ? q0[0] : '0;
    data1 = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // Advance one cycle; the FIFO models retire a word whenever the DUT popped it.
  task automatic tick();
    logic p0, p1;
    p0 = pop0;
    p1 = pop1;
    @(posedge clk);
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    @(negedge clk);
    apply_fifo();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    af_down0 = 1'b0; af_down1 = 1'b0;
    fifo_error0 = 1'b0; fifo_error1 = 1'b0;
    almost_full0 = 1'b0; almost_full1 = 1'b0;
    apply_fifo();
    k0 = 0; k1 = 0;
    exp_word = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_row(input vec_t v, input string tag, input int i);
    af_down0 = v.af0;
    af_down1 = v.af1;
    #1;
    chk($sformatf("%s[%0d].pop0", tag, i), {31'd0, pop0}, {31'd0, v.p0});
    chk($sformatf("%s[%0d].pop1", tag, i), {31'd0, pop1}, {31'd0, v.p1});
    chk($sformatf("%s[%0d].valid", tag, i), {31'd0, valid_out}, {31'd0, v.v});
    if (v.v) begin
      chk($sformatf("%s[%0d].class", tag, i), {31'd0, class_out}, {31'd0, v.cls});
      chk($sformatf("%s[%0d].data", tag, i), {22'd0, data_out}, {22'd0, exp_word});
    end
    $display("%s row %0d: pop0=%b pop1=%b valid=%b class=%b data=%h", tag, i,
             pop0, pop1, valid_out, class_out, data_out);
    if (v.p0) begin
      exp_word = base0 + DW'(k0);
      k0++;
    end else if (v.p1) begin
      exp_word = base1 + DW'(k1);
      k1++;
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Both backlogged, weights 3/1, last_served starts at class 1.
    tbl2[0] = mk(0,0, 0,0, 0,0);
    tbl2[1] = mk(0,0, 1,0, 0,0);
    tbl2[2] = mk(0,0, 1,0, 1,0);
    tbl2[3] = mk(0,0, 1,0, 1,0);
    tbl2[4] = mk(0,0, 0,1, 1,0);
    tbl2[5] = mk(0,0, 1,0, 1,1);
    tbl2[6] = mk(0,0, 1,0, 1,0);
    tbl2[7] = mk(0,0, 1,0, 1,0);
    tbl2[8] = mk(0,0, 0,1, 1,0);
    // Only class 1 with 5 words: work-conserving back-to-back pops, then IDLE.
    tbl3[0] = mk(0,0, 0,0, 0,0);
    tbl3[1] = mk(0,0, 0,1, 0,0);
    tbl3[2] = mk(0,0, 0,1, 1,1);
    tbl3[3] = mk(0,0, 0,1, 1,1);
    tbl3[4] = mk(0,0, 0,1, 1,1);
    tbl3[5] = mk(0,0, 0,1, 1,1);
    tbl3[6] = mk(0,0, 0,0, 1,1);
    tbl3[7] = mk(0,0, 0,0, 0,1);
    // Both backlogged, af_down0 high in cycles 10-15: one bubble when class 0 loses its turn.
    tbl4[0]  = mk(0,0, 0,0, 0,0);
    tbl4[1]  = mk(0,0, 1,0, 0,0);
    tbl4[2]  = mk(0,0, 1,0, 1,0);
    tbl4[3]  = mk(0,0, 1,0, 1,0);
    tbl4[4]  = mk(0,0, 0,1, 1,0);
    tbl4[5]  = mk(0,0, 1,0, 1,1);
    tbl4[6]  = mk(0,0, 1,0, 1,0);
    tbl4[7]  = mk(0,0, 1,0, 1,0);
    tbl4[8]  = mk(0,0, 0,1, 1,0);
    tbl4[9]  = mk(0,0, 1,0, 1,1);
    tbl4[10] = mk(1,0, 0,0, 1,0);
    tbl4[11] = mk(1,0, 0,1, 0,0);
    tbl4[12] = mk(1,0, 0,1, 1,1);
    tbl4[13] = mk(1,0, 0,1, 1,1);
    tbl4[14] = mk(1,0, 0,1, 1,1);
    tbl4[15] = mk(1,0, 0,1, 1,1);
    tbl4[16] = mk(0,0, 0,1, 1,1);
    tbl4[17] = mk(0,0, 1,0, 1,1);
    tbl4[18] = mk(0,0, 1,0, 1,0);

    // Idle with both FIFOs empty.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("idle.pop0", {31'd0, pop0}, 32'd0);
      chk("idle.pop1", {31'd0, pop1}, 32'd0);
      chk("idle.valid", {31'd0, valid_out}, 32'd0);
      tick();
    end
    #1;
    chk("idle.pop_cnt0", {24'd0, pop_cnt0}, 32'd0);
    chk("idle.pop_cnt1", {24'd0, pop_cnt1}, 32'd0);
    chk("idle.error", {31'd0, error_flag}, 32'd0);
    chk("idle.data_out", {22'd0, data_out}, 32'd0);
    chk("idle.class_out", {31'd0, class_out}, 32'd0);
    chk("idle.pause_up0", {31'd0, pause_up0}, 32'd0);
    $display("idle: pop_cnt0=%0d pop_cnt1=%0d error=%b", pop_cnt0, pop_cnt1, error_flag);

    // Weighted round-robin 3:1, then reset in the middle of a class-0 burst.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(base0 + DW'(i));
      q1.push_back(base1 + DW'(i));
    end
    apply_fifo();
    for (int i = 0; i < 9; i++) run_row(tbl2[i], "wrr", i);
    #1;
    chk("wrr.pop_cnt0", {24'd0, pop_cnt0}, 32'd6);
    chk("wrr.pop_cnt1", {24'd0, pop_cnt1}, 32'd2);
    chk("wrr.next_pop0", {31'd0, pop0}, 32'd1);
    chk("wrr.last_data", {22'd0, data_out}, {22'd0, exp_word});
    reset = 1'b0;
    #1;
    chk("rst.pop0", {31'd0, pop0}, 32'd0);
    chk("rst.valid", {31'd0, valid_out}, 32'd0);
    chk("rst.data_out", {22'd0, data_out}, 32'd0);
    chk("rst.pop_cnt0", {24'd0, pop_cnt0}, 32'd0);
    $display("reset mid-burst: pop0=%b valid=%b pop_cnt0=%0d", pop0, valid_out, pop_cnt0);

    // Class 1 alone.
    do_reset();
    for (int i = 0; i < 5; i++) q1.push_back(base1 + DW'(i));
    apply_fifo();
    for (int i = 0; i < 8; i++) run_row(tbl3[i], "c1only", i);
    #1;
    chk("c1only.pop_cnt1", {24'd0, pop_cnt1}, 32'd5);
    chk("c1only.pop_cnt0", {24'd0, pop_cnt0}, 32'd0);

    // Downstream almost-full on class 0.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      q0.push_back(base0 + DW'(i));
      q1.push_back(base1 + DW'(i));
    end
    apply_fifo();
    for (int i = 0; i < 19; i++) run_row(tbl4[i], "afdown", i);
    #1;
    chk("afdown.pop_cnt0", {24'd0, pop_cnt0}, 32'd9);
    chk("afdown.pop_cnt1", {24'd0, pop_cnt1}, 32'd8);

    // Sticky error.
    do_reset();
    #1;
    chk("err.before", {31'd0, error_flag}, 32'd0);
    fifo_error1 = 1'b1;
    tick();
    fifo_error1 = 1'b0;
    #1;
    chk("err.set", {31'd0, error_flag}, 32'd1);
    repeat (3) tick();
    #1;
    chk("err.held", {31'd0, error_flag}, 32'd1);
    reset = 1'b0;
    #1;
    chk("err.cleared", {31'd0, error_flag}, 32'd0);
    $display("error: cleared by reset, Error=%b", error_flag);

    // Pop counter wrap and upstream pause forwarding.
    do_reset();
    for (int i = 0; i < 256; i++) q0.push_back(base0 + DW'(i));
    apply_fifo();
    begin
      logic prev_af0, prev_af1;
      prev_af0 = 1'b0;
      prev_af1 = 1'b0;
      for (int t = 0; t < 258; t++) begin
        almost_full0 = (t % 2 == 1);
        almost_full1 = (t % 3 == 0);
        #1;
        if (t >= 1 && t <= 12) begin
          chk($sformatf("pause0[%0d]", t), {31'd0, pause_up0}, {31'd0, prev_af0});
          chk($sformatf("pause1[%0d]", t), {31'd0, pause_up1}, {31'd0, prev_af1});
        end
        if (t == 256) begin
          chk("wrap.cnt255", {24'd0, pop_cnt0}, 32'd255);
          chk("wrap.last_pop0", {31'd0, pop0}, 32'd1);
        end
        if (t == 257) begin
          chk("wrap.cnt0", {24'd0, pop_cnt0}, 32'd0);
          chk("wrap.no_pop0", {31'd0, pop0}, 32'd0);
          $display("wrap: pop_cnt0=%0d after 256 pops", pop_cnt0);
        end
        prev_af0 = almost_full0;
        prev_af1 = almost_full1;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
